// File: rtl/adder_result_queue_if.sv
// adder_result_queue_if: producer/consumer handshake bundle for the adder result queue (stats ports under ADDER_RESULT_QUEUE_STATS_EN)
interface adder_result_queue_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_sum;
   logic                     in_cout;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_sum;
   logic                     out_cout;
   logic                     out_zero;
   logic [$clog2(DEPTH):0]   count;
`ifdef ADDER_RESULT_QUEUE_STATS_EN
   logic [15:0]              acc_cnt;
   logic [15:0]              carry_cnt;
   modport slave (
      input  in_valid, in_sum, in_cout, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_zero, count, acc_cnt, carry_cnt
   );
   modport master (
      output in_valid, in_sum, in_cout, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_zero, count, acc_cnt, carry_cnt
   );
`else
   modport slave (
      input  in_valid, in_sum, in_cout, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_zero, count
   );
   modport master (
      output in_valid, in_sum, in_cout, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_zero, count
   );
`endif
endinterface

// File: rtl/adder_result_queue.sv
// adder_result_queue: registered DEPTH-entry FIFO for {sum, cout} with per-entry zero flag; ADDER_RESULT_QUEUE_STATS_EN adds push/carry counters
module adder_result_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   adder_result_queue_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH+1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH+1:0] r_head;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_rd_next;
   logic [CW-1:0]    w_count_next;
   logic [WIDTH+1:0] w_in_entry;
   logic [WIDTH+1:0] w_head_next;

   // Handshake decode and next head selection; the freshly written entry bypasses storage when it becomes the head
   always_comb begin
      w_push       = bus.in_valid & bus.in_ready;
      w_pop        = bus.out_valid & bus.out_ready;
      w_rd_next    = r_rd_ptr + PW'(w_pop);
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      w_in_entry   = {(bus.in_sum == '0) & ~bus.in_cout, bus.in_cout, bus.in_sum};
      w_head_next  = (w_push && r_wr_ptr == w_rd_next) ? w_in_entry : r_mem[w_rd_next];
   end

   // Entry storage, written on push only and never cleared
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
   end

   // Pointers, occupancy and the registered head copy; head holds its last value once the queue empties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_push);
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         if (w_count_next != '0) r_head <= w_head_next;
      end
   end

   assign bus.in_ready  = r_count != CW'(DEPTH);
   assign bus.out_valid = r_count != '0;
   assign bus.out_sum   = r_head[WIDTH-1:0];
   assign bus.out_cout  = r_head[WIDTH];
   assign bus.out_zero  = r_head[WIDTH+1];
   assign bus.count     = r_count;

`ifdef ADDER_RESULT_QUEUE_STATS_EN
   logic [15:0] r_acc_cnt;
   logic [15:0] r_carry_cnt;

   // Saturating counts of accepted results and of accepted results carrying out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_cnt   <= '0;
         r_carry_cnt <= '0;
      end else if (w_push) begin
         r_acc_cnt   <= (r_acc_cnt == 16'hFFFF) ? r_acc_cnt : r_acc_cnt + 16'd1;
         r_carry_cnt <= (!bus.in_cout || r_carry_cnt == 16'hFFFF) ? r_carry_cnt : r_carry_cnt + 16'd1;
      end
   end

   assign bus.acc_cnt   = r_acc_cnt;
   assign bus.carry_cnt = r_carry_cnt;
`endif
endmodule

// File: tb/tb_adder_result_queue.sv
// tb_adder_result_queue: table-driven vectors plus directed sequences for wrap, async reset and optional stats saturation
module tb_adder_result_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   adder_result_queue_if #(.WIDTH(8), .DEPTH(4)) bus ();

   adder_result_queue #(.WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] s;
      logic       c;
      logic       r;
      logic       ev;
      logic [7:0] es;
      logic       ec;
      logic       ez;
      logic [2:0] ecnt;
      logic       eir;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] s, input logic c, input logic r);
      bus.in_valid  = v;
      bus.in_sum    = s;
      bus.in_cout   = c;
      bus.out_ready = r;
   endtask

   // Stimulus and checking sequence
   initial begin
      tbl[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd3, 1'b1};
      tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 1'b0};
      tbl[5]  = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 3'd3, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1};
      tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1};
      tbl[13] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1};
      tbl[14] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b1};

      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset count", 32'(bus.count), 32'd0);
      chk("reset out_sum", 32'(bus.out_sum), 32'd0);
      chk("reset out_cout", 32'(bus.out_cout), 32'd0);
      chk("reset out_zero", 32'(bus.out_zero), 32'd0);
`ifdef ADDER_RESULT_QUEUE_STATS_EN
      chk("reset acc_cnt", 32'(bus.acc_cnt), 32'd0);
      chk("reset carry_cnt", 32'(bus.carry_cnt), 32'd0);
`endif

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].r);
         step();
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d out_sum", i), 32'(bus.out_sum), 32'(tbl[i].es));
         chk($sformatf("vec%0d out_cout", i), 32'(bus.out_cout), 32'(tbl[i].ec));
         chk($sformatf("vec%0d out_zero", i), 32'(bus.out_zero), 32'(tbl[i].ez));
         chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(tbl[i].ecnt));
         chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].eir));
      end

      // Steady stream from count=1: each edge pops the old head and pushes a new one, crossing several pointer wraps
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 8'(8'h10 + k), 1'b0, 1'b1);
         step();
         chk($sformatf("stream%0d out_sum", k), 32'(bus.out_sum), 32'(8'h10 + k));
         chk($sformatf("stream%0d count", k), 32'(bus.count), 32'd1);
      end

      // Build up to three entries, then assert reset between edges
      drive(1'b1, 8'hA1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'hA2, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre-reset count", 32'(bus.count), 32'd3);
      chk("pre-reset head", 32'(bus.out_sum), 32'h23);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("async reset count", 32'(bus.count), 32'd0);
      chk("async reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("async reset out_sum", 32'(bus.out_sum), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("post-reset count", 32'(bus.count), 32'd0);

`ifdef ADDER_RESULT_QUEUE_STATS_EN
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'(k), (k % 3 == 0) && (k < 9), 1'b1);
         step();
      end
      chk("stats acc_cnt 10", 32'(bus.acc_cnt), 32'd10);
      chk("stats carry_cnt 3", 32'(bus.carry_cnt), 32'd3);
      for (int k = 0; k < 65525; k++) begin
         drive(1'b1, 8'(k), 1'b0, 1'b1);
         step();
      end
      chk("stats acc_cnt full", 32'(bus.acc_cnt), 32'hFFFF);
      drive(1'b1, 8'h00, 1'b1, 1'b1);
      step();
      chk("stats acc_cnt saturated", 32'(bus.acc_cnt), 32'hFFFF);
      chk("stats carry_cnt 4", 32'(bus.carry_cnt), 32'd4);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
